// File: rtl/cursor_engine_pkg.sv
// Shared cursor types for the terminal parser blocks.
// Opcodes, cursor position and scroll request layouts.
package cursor_engine_pkg;

    localparam int CURSOR_W = 8;

    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_CUP     = 4'd1,
        OP_CUU     = 4'd2,
        OP_CUD     = 4'd3,
        OP_CUF     = 4'd4,
        OP_CUB     = 4'd5,
        OP_IND     = 4'd6,
        OP_RI      = 4'd7,
        OP_CR      = 4'd8,
        OP_BS      = 4'd9,
        OP_PUT     = 4'd10,
        OP_NEL     = 4'd11,
        OP_SAVE    = 4'd12,
        OP_RESTORE = 4'd13,
        OP_HOME    = 4'd14,
        OP_RSVD    = 4'd15
    } cursor_op_e;

    typedef enum logic {
        SCROLL_UP   = 1'b0,
        SCROLL_DOWN = 1'b1
    } scroll_dir_e;

    typedef struct packed {
        logic [CURSOR_W-1:0] row;
        logic [CURSOR_W-1:0] col;
        logic                wrap;
    } cursor_pos_t;

    typedef struct packed {
        scroll_dir_e         dir;
        logic [CURSOR_W-1:0] lo;
        logic [CURSOR_W-1:0] hi;
    } scroll_req_t;

endpackage

// File: rtl/cursor_engine_save_stack.sv
// LIFO of saved cursor positions (DECSC/DECRC).
// A push while full overwrites the top entry and sets a sticky flag.
module cursor_save_stack
    import cursor_engine_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = cursor_pos_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  logic   pop_i,
    input  entry_t din_i,
    output entry_t top_o,
    output logic   empty_o,
    output logic   overflow_o
);

    localparam int CW = $clog2(DEPTH + 1);

    entry_t         mem_q [1 << CW];
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  top_idx;
    logic [CW-1:0]  wr_idx;
    logic           full;
    logic           ovf_q;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign top_idx = cnt_q - CW'(1);
    assign wr_idx  = full ? top_idx : cnt_q;
    assign top_o   = mem_q[top_idx];
    assign overflow_o = ovf_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_idx] <= din_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (push_i) begin
            if (full) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/cursor_engine.sv
// Cursor tracker: moves, deferred autowrap, save stack and
// scroll requests handed to the text-buffer scroller.
module cursor_engine
    import cursor_engine_pkg::*;
#(
    parameter int ROWS       = 30,
    parameter int COLS       = 80,
    parameter int W          = 8,
    parameter int SAVE_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [W-1:0] cmd_arg1,
    input  logic [W-1:0] cmd_arg2,
    input  logic         origin_mode,
    input  logic         auto_wrap,
    input  logic [W-1:0] scroll_top,
    input  logic [W-1:0] scroll_bottom,
    output logic [W-1:0] cur_row,
    output logic [W-1:0] cur_col,
    output logic         wrap_pending,
    output logic         scroll_valid,
    input  logic         scroll_ready,
    output logic         scroll_dir,
    output logic [W-1:0] scroll_lo,
    output logic [W-1:0] scroll_hi,
    output logic         save_overflow,
    output logic         blink_reset
);

    typedef logic [W:0] wide_t;

    typedef struct packed {
        logic [W-1:0] row;
        logic [W-1:0] col;
        logic         wrap;
    } pos_t;

    typedef enum logic {S_IDLE, S_SCROLL} state_e;

    localparam wide_t        ROW_MAX = wide_t'(ROWS - 1);
    localparam wide_t        COL_MAX = wide_t'(COLS - 1);
    localparam logic [W-1:0] ONE     = W'(1);

    function automatic wide_t wmin(input wide_t a, input wide_t b);
        return (a < b) ? a : b;
    endfunction

    state_e       state_q;
    logic         ready_q, svalid_q;
    logic [W-1:0] row_q, row_d, col_q, col_d;
    logic         wrap_q, wrap_d;
    scroll_dir_e  dir_q, dir_d;
    logic [W-1:0] lo_q, hi_q;
    logic         blink_q, blink_d;
    logic         scroll_req, push, pop, accept;
    logic         stk_empty, lf_scroll;
    logic [W-1:0] lf_row, home_row;
    pos_t         top_pos, save_pos;
    cursor_op_e   op;
    wide_t        a1, a2, rw, cl, top_w, bot_w;
    wide_t        n, r, c, floor_w, ceil_w;

    assign op       = cursor_op_e'(cmd_op);
    assign accept   = cmd_valid && ready_q;
    assign save_pos = '{row: row_q, col: col_q, wrap: wrap_q};

    always_comb begin
        a1    = {1'b0, cmd_arg1};
        a2    = {1'b0, cmd_arg2};
        rw    = {1'b0, row_q};
        cl    = {1'b0, col_q};
        top_w = {1'b0, scroll_top};
        bot_w = {1'b0, scroll_bottom};
        n     = (a1 == '0) ? wide_t'(1) : a1;
        r     = (a1 == '0) ? '0 : a1 - wide_t'(1);
        c     = (a2 == '0) ? '0 : a2 - wide_t'(1);
        floor_w = (rw >= top_w) ? top_w : '0;
        ceil_w  = (rw <= bot_w) ? bot_w : ROW_MAX;
        // Line feed motion shared by IND, NEL and wrapping PUT
        lf_scroll = (rw == bot_w);
        lf_row    = (!lf_scroll && rw < ROW_MAX) ? row_q + ONE : row_q;
        home_row  = origin_mode ? scroll_top : '0;

        row_d      = row_q;
        col_d      = col_q;
        wrap_d     = wrap_q;
        dir_d      = SCROLL_UP;
        scroll_req = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        blink_d    = 1'b0;

        if (accept) begin
            blink_d = !(op inside {OP_NOP, OP_SAVE, OP_RSVD});
            if (!(op inside {OP_PUT, OP_SAVE, OP_NOP, OP_RSVD}))
                wrap_d = 1'b0;
            unique case (op)
                OP_CUP: begin
                    row_d = origin_mode ? W'(wmin(top_w + r, bot_w))
                                        : W'(wmin(r, ROW_MAX));
                    col_d = W'(wmin(c, COL_MAX));
                end
                OP_CUU: row_d = (rw < floor_w + n) ? W'(floor_w) : W'(rw - n);
                OP_CUD: row_d = W'(wmin(rw + n, ceil_w));
                OP_CUF: col_d = W'(wmin(cl + n, COL_MAX));
                OP_CUB: col_d = (cl < n) ? '0 : W'(cl - n);
                OP_IND: begin
                    row_d      = lf_row;
                    scroll_req = lf_scroll;
                end
                OP_NEL: begin
                    row_d      = lf_row;
                    scroll_req = lf_scroll;
                    col_d      = '0;
                end
                OP_RI: begin
                    if (rw == top_w) begin
                        scroll_req = 1'b1;
                        dir_d      = SCROLL_DOWN;
                    end else if (row_q != '0) begin
                        row_d = row_q - ONE;
                    end
                end
                OP_CR: col_d = '0;
                OP_BS: col_d = (col_q == '0) ? '0 : col_q - ONE;
                OP_PUT: begin
                    if (wrap_q && auto_wrap) begin
                        row_d      = lf_row;
                        scroll_req = lf_scroll;
                        col_d      = ONE;
                        wrap_d     = 1'b0;
                    end else if (cl < COL_MAX) begin
                        col_d  = col_q + ONE;
                        wrap_d = 1'b0;
                    end else begin
                        wrap_d = auto_wrap;
                    end
                end
                OP_SAVE: push = 1'b1;
                OP_RESTORE: begin
                    if (!stk_empty) begin
                        pop    = 1'b1;
                        row_d  = top_pos.row;
                        col_d  = top_pos.col;
                        wrap_d = top_pos.wrap;
                    end else begin
                        row_d = home_row;
                        col_d = '0;
                    end
                end
                OP_HOME: begin
                    row_d = home_row;
                    col_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            svalid_q <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            wrap_q   <= 1'b0;
            dir_q    <= SCROLL_UP;
            lo_q     <= '0;
            hi_q     <= '0;
            blink_q  <= 1'b0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            wrap_q  <= wrap_d;
            blink_q <= blink_d;
            unique case (state_q)
                S_IDLE: begin
                    if (scroll_req) begin
                        state_q  <= S_SCROLL;
                        ready_q  <= 1'b0;
                        svalid_q <= 1'b1;
                        dir_q    <= dir_d;
                        lo_q     <= scroll_top;
                        hi_q     <= scroll_bottom;
                    end
                end
                S_SCROLL: begin
                    if (scroll_ready) begin
                        state_q  <= S_IDLE;
                        ready_q  <= 1'b1;
                        svalid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    cursor_save_stack #(
        .DEPTH   (SAVE_DEPTH),
        .entry_t (pos_t)
    ) u_stack (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .pop_i      (pop),
        .din_i      (save_pos),
        .top_o      (top_pos),
        .empty_o    (stk_empty),
        .overflow_o (save_overflow)
    );

    assign cmd_ready    = ready_q;
    assign scroll_valid = svalid_q;
    assign scroll_dir   = dir_q;
    assign scroll_lo    = lo_q;
    assign scroll_hi    = hi_q;
    assign cur_row      = row_q;
    assign cur_col      = col_q;
    assign wrap_pending = wrap_q;
    assign blink_reset  = blink_q;

endmodule

// File: doc/cursor_engine.md
Name: cursor_engine

Overview:
Parametrised next-generation cursor tracker for the terminal parser. It accepts decoded cursor commands over a valid/ready handshake and maintains the absolute cursor position against a scroll region and origin mode. It adds deferred (VT100-style) autowrap and a save/restore stack for DECSC/DECRC. Scroll requests go to the text-buffer scroller over their own valid/ready handshake.

Parameters:
ROWS, 30, screen lines; must be at least 2.
COLS, 80, screen columns; must be at least 2.
W, 8, coordinate/count width; 2**W must exceed max(ROWS, COLS).
SAVE_DEPTH, 4, entries in the cursor save stack; must be at least 1.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  4  opcode: 0 NOP, 1 CUP, 2 CUU, 3 CUD, 4 CUF, 5 CUB, 6 IND/LF, 7 RI, 8 CR, 9 BS, 10 PUT, 11 NEL, 12 SAVE, 13 RESTORE, 14 HOME; 15 reserved, treated as NOP
cmd_arg1  in  W  count, or row (1-based) for CUP
cmd_arg2  in  W  column (1-based) for CUP
origin_mode  in  1  CUP/HOME rows are relative to scroll_top
auto_wrap  in  1  autowrap enable
scroll_top  in  W  region top row, absolute
scroll_bottom  in  W  region bottom row, absolute, >= scroll_top
cur_row  out  W  absolute cursor row
cur_col  out  W  cursor column
wrap_pending  out  1  deferred-wrap flag
scroll_valid  out  1  scroll request pending
scroll_ready  in  1  scroller accepts the request
scroll_dir  out  1  0 = up (content moves up), 1 = down
scroll_lo  out  W  region top captured at request time
scroll_hi  out  W  region bottom captured at request time
save_overflow  out  1  sticky; set on a push while the stack is full
blink_reset  out  1  one-cycle pulse on every accepted op other than NOP/SAVE

Behaviour:
- Reset values:
  - cur_row = 0, cur_col = 0.
  - wrap_pending = 0, scroll_valid = 0, save_overflow = 0, blink_reset = 0.
  - Stack empty; FSM in IDLE.
- FSM states:
  - IDLE: cmd_ready = 1.
  - SCROLL: cmd_ready = 0, scroll_valid = 1.
  - SCROLL -> IDLE on the edge where scroll_valid && scroll_ready.
- Accept latency: an accepted command updates the cursor at the same clock edge, so new values are visible the next cycle.
  - A scrolling op enters SCROLL at that edge.
  - scroll_dir, scroll_lo and scroll_hi are registered at that edge and held stable until the handshake completes.
- Count n = (cmd_arg1 == 0) ? 1 : cmd_arg1. All arithmetic is done in W+1 bits before clamping, so there is no wrap-around.
- CUP:
  - Row r = arg1 - 1 (0 if arg1 == 0). Column c = arg2 - 1 (0 if arg2 == 0).
  - origin_mode = 1: row = min(scroll_top + r, scroll_bottom).
  - origin_mode = 0: row = min(r, ROWS-1).
  - col = min(c, COLS-1).
- CUU: floor is scroll_top if cur_row >= scroll_top, else 0. row = max(row - n, floor).
- CUD: ceiling is scroll_bottom if cur_row <= scroll_bottom, else ROWS-1. row = min(row + n, ceiling).
- CUF: col = min(col + n, COLS-1).
- CUB: col = max(col - n, 0).
- CUU, CUD, CUF, CUB never scroll.
- IND/LF:
  - If cur_row == scroll_bottom: row unchanged, scroll up 1.
  - Else if row < ROWS-1: row + 1.
  - Else (row == ROWS-1): no move, no scroll.
- NEL: same as IND/LF, and col = 0.
- RI: if cur_row == scroll_top, row unchanged and scroll down 1; else if row > 0, row - 1.
- CR: col = 0. BS: col = max(col - 1, 0).
- PUT (printable character written at the pre-op cursor by another block):
  - wrap_pending = 1 and auto_wrap = 1: perform the NEL motion (may scroll), then col = 1, wrap_pending = 0.
  - Else if col < COLS-1: col + 1.
  - Else (col == COLS-1): wrap_pending = auto_wrap and cursor stays.
- wrap_pending is cleared by every op except PUT, SAVE and NOP.
- wrap_pending is also cleared whenever auto_wrap is sampled 0 on an accepted PUT.
- SAVE: push {row, col, wrap_pending}. If the stack is full, overwrite the top entry and set save_overflow.
- RESTORE:
  - Non-empty stack: pop and load row, col and wrap_pending.
  - Empty stack: home to (origin_mode ? scroll_top : 0, 0) with wrap_pending = 0.
- HOME: row = origin_mode ? scroll_top : 0; col = 0.
- cmd_valid while cmd_ready = 0 is ignored; the source must hold the command.
- Reset mid-SCROLL drops the request immediately and empties the stack.

Decomposition:
- Shared package: cursor_op_e enum, cursor_pos_t struct {row, col, wrap}, and the scroll request struct. Other parser blocks import these types from the package.
- One sub-module: cursor_save_stack.
  - Parametrised LIFO with push/pop, full/empty and overflow-overwrite.
  - Asynchronous reset.
  - Single-cycle push/pop; a pop returns the top entry combinationally.

Test Plan:
- CUP arg1=40, arg2=100, origin 0 -> (29,79); then origin 1 with top=5, bottom=20, CUP arg1=3, arg2=0 -> (7,0); CUP arg1=99 -> row 20.
- Cursor (20,10), region 5..20: IND -> row stays 20, scroll_valid=1, dir=0, lo=5, hi=20. Hold scroll_ready=0 for 3 cycles -> cmd_ready=0 and outputs stable. Then ready=1 -> back to IDLE.
- auto_wrap=1, col 78: PUT -> col 79, wrap=0; PUT -> wrap=1, col 79; PUT -> row+1, col 1, wrap=0; CR in place of the third PUT -> col 0, wrap=0.
- Cursor (5,3), top=5: RI -> scroll dir=1; at row 4 (outside region): CUU arg1=9 -> row 0; at row 25, bottom=20: CUD arg1=9 -> row 29.
- SAVE_DEPTH=4: five SAVEs at distinct positions -> save_overflow=1; four RESTOREs return the 5th, 3rd, 2nd and 1st positions in that order; a fifth RESTORE homes to (0,0).
- Assert rst during SCROLL -> scroll_valid=0, cursor (0,0), stack empty, and cmd_ready=1 after release.
